// File: rtl/da_pkg.sv
// Shared types and helpers for the distributed-arithmetic GEMM output path.
package da_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } collector_state_t;

    // Clamp a wide signed value to the range of a signed field of the given width.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                      input int                 width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/da_requant.sv
// One combinational requantization lane: optional ReLU, round-half-up right shift, saturation.
module da_requant
    import da_pkg::*;
#(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT     = 0,
    parameter bit RELU_EN   = 1'b0
) (
    input  logic signed [IN_WIDTH-1:0]  in_val,
    output logic signed [OUT_WIDTH-1:0] out_val
);

    // One guard bit so adding the rounding constant to the largest input cannot wrap.
    localparam int EXT_W   = IN_WIDTH + 1;
    localparam int RND_BIT = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [EXT_W-1:0] RND = (SHIFT > 0) ? (EXT_W'(1) << RND_BIT) : '0;

    function automatic logic signed [EXT_W-1:0] round_shift(input logic signed [EXT_W-1:0] x);
        if (SHIFT == 0) begin
            return x;
        end
        return (x + RND) >>> SHIFT;
    endfunction

    logic signed [EXT_W-1:0] x_ext;

    always_comb begin
        x_ext = EXT_W'(in_val);
        if (RELU_EN && (x_ext < 0)) begin
            x_ext = '0;
        end
        out_val = OUT_WIDTH'(sat_signed(64'(round_shift(x_ext)), OUT_WIDTH));
    end

endmodule

// File: rtl/da_row_collector.sv
// Collects requantized engine rows into an M-row tile and drains it one row per valid/ready beat.
module da_row_collector
    import da_pkg::*;
#(
    parameter int N         = 1,
    parameter int M         = 1,
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT     = 0,
    parameter bit RELU_EN   = 1'b0,
    localparam int PTR_W    = (M > 1) ? $clog2(M) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        in_valid,
    input  logic signed [IN_WIDTH-1:0]  in_data [N],
    output logic                        in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] out_data [N],
    output logic [PTR_W-1:0]            out_row,
    output logic                        out_last,
    output logic                        err_overflow
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(M - 1);

    collector_state_t state;
    collector_state_t state_nxt;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic signed [OUT_WIDTH-1:0] rq_row  [N];
    logic signed [OUT_WIDTH-1:0] buf_mem [M][N];

    logic wr_fire;
    logic rd_fire;
    logic ovf_hit;

    for (genvar g = 0; g < N; g++) begin : g_lane
        da_requant #(
            .IN_WIDTH  (IN_WIDTH),
            .OUT_WIDTH (OUT_WIDTH),
            .SHIFT     (SHIFT),
            .RELU_EN   (RELU_EN)
        ) u_requant (
            .in_val  (in_data[g]),
            .out_val (rq_row[g])
        );
    end

    // clear overrides everything: it suppresses writes, beats and new overflow events.
    assign wr_fire = in_valid && (state == FILL) && !clear;
    assign rd_fire = out_valid && out_ready && !clear;
    assign ovf_hit = in_valid && (state == DRAIN) && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = FILL;
        end else begin
            case (state)
                FILL:    if (wr_fire && (wr_ptr == LAST)) state_nxt = DRAIN;
                DRAIN:   if (rd_fire && (rd_ptr == LAST)) state_nxt = FILL;
                default: state_nxt = FILL;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == FILL);
        out_valid = (state == DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_overflow <= 1'b0;
        end else if (ovf_hit) begin
            err_overflow <= 1'b1;
        end
    end

    // Row select by comparison rather than pointer indexing keeps M=1 free of zero-width selects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < M; r++) begin
                for (int c = 0; c < N; c++) begin
                    buf_mem[r][c] <= '0;
                end
            end
        end else if (wr_fire) begin
            for (int r = 0; r < M; r++) begin
                if (wr_ptr == PTR_W'(r)) begin
                    buf_mem[r] <= rq_row;
                end
            end
        end
    end

    always_comb begin
        out_data = buf_mem[0];
        for (int r = 1; r < M; r++) begin
            if (rd_ptr == PTR_W'(r)) begin
                out_data = buf_mem[r];
            end
        end
        out_row  = rd_ptr;
        out_last = out_valid && (rd_ptr == LAST);
    end

endmodule

// File: tb/tb_da_row_collector.sv
// Directed bench for da_row_collector: tile flow, requantization, backpressure, overflow, clear, reset.
module tb_da_row_collector;

    logic clk;
    logic rst_n;
    logic clear;

    int checks;
    int errors;

    // Instance A: N=2, M=2, 8->8 bits, no shift.
    logic              a_in_valid;
    logic signed [7:0] a_in_data [2];
    logic              a_in_ready;
    logic              a_out_valid;
    logic              a_out_ready;
    logic signed [7:0] a_out_data [2];
    logic [0:0]        a_out_row;
    logic              a_out_last;
    logic              a_err;

    // Instance Q: N=4, M=1, 8->4 bits, SHIFT=2, no ReLU.
    logic              q_in_valid;
    logic signed [7:0] q_in_data [4];
    logic              q_in_ready;
    logic              q_out_valid;
    logic              q_out_ready;
    logic signed [3:0] q_out_data [4];
    logic [0:0]        q_out_row;
    logic              q_out_last;
    logic              q_err;

    // Instance R: N=2, M=1, 8->4 bits, SHIFT=2, ReLU on.
    logic              r_in_valid;
    logic signed [7:0] r_in_data [2];
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_out_ready;
    logic signed [3:0] r_out_data [2];
    logic [0:0]        r_out_row;
    logic              r_out_last;
    logic              r_err;

    da_row_collector #(.N(2), .M(2), .IN_WIDTH(8), .OUT_WIDTH(8), .SHIFT(0), .RELU_EN(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_row(a_out_row), .out_last(a_out_last), .err_overflow(a_err)
    );

    da_row_collector #(.N(4), .M(1), .IN_WIDTH(8), .OUT_WIDTH(4), .SHIFT(2), .RELU_EN(1'b0)) dut_q (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(q_in_valid), .in_data(q_in_data), .in_ready(q_in_ready),
        .out_valid(q_out_valid), .out_ready(q_out_ready), .out_data(q_out_data),
        .out_row(q_out_row), .out_last(q_out_last), .err_overflow(q_err)
    );

    da_row_collector #(.N(2), .M(1), .IN_WIDTH(8), .OUT_WIDTH(4), .SHIFT(2), .RELU_EN(1'b1)) dut_r (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(r_in_valid), .in_data(r_in_data), .in_ready(r_in_ready),
        .out_valid(r_out_valid), .out_ready(r_out_ready), .out_data(r_out_data),
        .out_row(r_out_row), .out_last(r_out_last), .err_overflow(r_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_row(input logic signed [7:0] d0, input logic signed [7:0] d1);
        a_in_data[0] = d0;
        a_in_data[1] = d1;
        a_in_valid   = 1'b1;
        tick();
        a_in_valid   = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_row !== 1'b0 ||
            a_out_last !== 1'b0 || a_err !== 1'b0 || a_out_data[0] !== 8'sd0 || a_out_data[1] !== 8'sd0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%0b vld=%0b row=%0d last=%0b err=%0b data=%0d,%0d expected 1 0 0 0 0 0,0",
                     a_in_ready, a_out_valid, a_out_row, a_out_last, a_err, a_out_data[0], a_out_data[1]);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_tile();
        a_row(8'sd5, -8'sd3);
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_after_row0: got rdy=%0b vld=%0b expected 1 0", a_in_ready, a_out_valid);
        end
        a_row(8'sd127, -8'sd128);
        checks++;
        if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_out_row !== 1'b0 || a_out_last !== 1'b0 ||
            a_out_data[0] !== 8'sd5 || a_out_data[1] !== -8'sd3) begin
            errors++;
            $display("FAIL basic_beat0: got vld=%0b rdy=%0b row=%0d last=%0b data=%0d,%0d expected 1 0 0 0 5,-3",
                     a_out_valid, a_in_ready, a_out_row, a_out_last, a_out_data[0], a_out_data[1]);
        end
        a_out_ready = 1'b1;
        tick();
        checks++;
        if (a_out_valid !== 1'b1 || a_out_row !== 1'b1 || a_out_last !== 1'b1 ||
            a_out_data[0] !== 8'sd127 || a_out_data[1] !== -8'sd128) begin
            errors++;
            $display("FAIL basic_beat1: got vld=%0b row=%0d last=%0b data=%0d,%0d expected 1 1 1 127,-128",
                     a_out_valid, a_out_row, a_out_last, a_out_data[0], a_out_data[1]);
        end
        tick();
        a_out_ready = 1'b0;
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_last !== 1'b0) begin
            errors++;
            $display("FAIL basic_refill: got rdy=%0b vld=%0b last=%0b expected 1 0 0", a_in_ready, a_out_valid, a_out_last);
        end
    endtask

    task automatic test_requant();
        q_in_data[0] = 8'sd100;
        q_in_data[1] = -8'sd9;
        q_in_data[2] = 8'sd6;
        q_in_data[3] = -8'sd128;
        q_in_valid   = 1'b1;
        tick();
        q_in_valid   = 1'b0;
        checks++;
        if (q_out_valid !== 1'b1 || q_out_last !== 1'b1 || q_in_ready !== 1'b0 ||
            q_out_data[0] !== 4'sd7 || q_out_data[1] !== -4'sd2 || q_out_data[2] !== 4'sd2 || q_out_data[3] !== -4'sd8) begin
            errors++;
            $display("FAIL requant_sat: got vld=%0b last=%0b data=%0d,%0d,%0d,%0d expected 1 1 7,-2,2,-8",
                     q_out_valid, q_out_last, q_out_data[0], q_out_data[1], q_out_data[2], q_out_data[3]);
        end
        q_out_ready = 1'b1;
        tick();
        checks++;
        if (q_out_valid !== 1'b0 || q_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL requant_m1_return: got vld=%0b rdy=%0b expected 0 1", q_out_valid, q_in_ready);
        end
        q_in_data[0] = 8'sd2;
        q_in_data[1] = -8'sd2;
        q_in_data[2] = -8'sd6;
        q_in_data[3] = 8'sd3;
        q_in_valid   = 1'b1;
        q_out_ready  = 1'b0;
        tick();
        q_in_valid   = 1'b0;
        checks++;
        if (q_out_data[0] !== 4'sd1 || q_out_data[1] !== 4'sd0 || q_out_data[2] !== -4'sd1 || q_out_data[3] !== 4'sd1) begin
            errors++;
            $display("FAIL requant_round_half_up: got %0d,%0d,%0d,%0d expected 1,0,-1,1",
                     q_out_data[0], q_out_data[1], q_out_data[2], q_out_data[3]);
        end
        q_out_ready = 1'b1;
        tick();
        q_out_ready = 1'b0;
    endtask

    task automatic test_relu();
        r_in_data[0] = -8'sd9;
        r_in_data[1] = 8'sd6;
        r_in_valid   = 1'b1;
        tick();
        r_in_valid   = 1'b0;
        checks++;
        if (r_out_valid !== 1'b1 || r_out_data[0] !== 4'sd0 || r_out_data[1] !== 4'sd2) begin
            errors++;
            $display("FAIL relu_basic: got vld=%0b data=%0d,%0d expected 1 0,2", r_out_valid, r_out_data[0], r_out_data[1]);
        end
        r_out_ready = 1'b1;
        tick();
        r_in_data[0] = 8'sd127;
        r_in_data[1] = -8'sd128;
        r_in_valid   = 1'b1;
        r_out_ready  = 1'b0;
        tick();
        r_in_valid   = 1'b0;
        checks++;
        if (r_out_data[0] !== 4'sd7 || r_out_data[1] !== 4'sd0) begin
            errors++;
            $display("FAIL relu_extremes: got %0d,%0d expected 7,0", r_out_data[0], r_out_data[1]);
        end
        r_out_ready = 1'b1;
        tick();
        r_out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        a_row(8'sd10, 8'sd20);
        a_row(8'sd30, 8'sd40);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (a_out_valid !== 1'b1 || a_out_row !== 1'b0 || a_out_data[0] !== 8'sd10 || a_out_data[1] !== 8'sd20) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: got vld=%0b row=%0d data=%0d,%0d expected 1 0 10,20",
                         i, a_out_valid, a_out_row, a_out_data[0], a_out_data[1]);
            end
            tick();
        end
        a_out_ready = 1'b1;
        tick();
        checks++;
        if (a_out_valid !== 1'b1 || a_out_row !== 1'b1 || a_out_last !== 1'b1 ||
            a_out_data[0] !== 8'sd30 || a_out_data[1] !== 8'sd40) begin
            errors++;
            $display("FAIL backpressure_release: got vld=%0b row=%0d last=%0b data=%0d,%0d expected 1 1 1 30,40",
                     a_out_valid, a_out_row, a_out_last, a_out_data[0], a_out_data[1]);
        end
        tick();
        a_out_ready = 1'b0;
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_done: got vld=%0b rdy=%0b expected 0 1", a_out_valid, a_in_ready);
        end
    endtask

    task automatic test_overflow();
        a_row(8'sd1, 8'sd2);
        a_row(8'sd3, 8'sd4);
        a_row(8'sd1, 8'sd1);
        checks++;
        if (a_err !== 1'b1 || a_out_valid !== 1'b1 || a_out_row !== 1'b0 ||
            a_out_data[0] !== 8'sd1 || a_out_data[1] !== 8'sd2) begin
            errors++;
            $display("FAIL overflow_flag: got err=%0b vld=%0b row=%0d data=%0d,%0d expected 1 1 0 1,2",
                     a_err, a_out_valid, a_out_row, a_out_data[0], a_out_data[1]);
        end
        a_out_ready = 1'b1;
        tick();
        checks++;
        if (a_out_row !== 1'b1 || a_out_data[0] !== 8'sd3 || a_out_data[1] !== 8'sd4) begin
            errors++;
            $display("FAIL overflow_data_kept: got row=%0d data=%0d,%0d expected 1 3,4", a_out_row, a_out_data[0], a_out_data[1]);
        end
        tick();
        a_out_ready = 1'b0;
        a_row(8'sd7, 8'sd8);
        a_row(8'sd9, 8'sd10);
        checks++;
        if (a_out_valid !== 1'b1 || a_err !== 1'b1 || a_out_data[0] !== 8'sd7 || a_out_data[1] !== 8'sd8) begin
            errors++;
            $display("FAIL overflow_next_tile: got vld=%0b err=%0b data=%0d,%0d expected 1 1 7,8",
                     a_out_valid, a_err, a_out_data[0], a_out_data[1]);
        end
        a_out_ready = 1'b1;
        tick();
        tick();
        a_out_ready = 1'b0;
    endtask

    task automatic test_clear_and_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        a_row(8'sd11, 8'sd12);
        clear        = 1'b1;
        a_in_data[0] = 8'sd99;
        a_in_data[1] = 8'sd99;
        a_in_valid   = 1'b1;
        tick();
        clear        = 1'b0;
        a_in_valid   = 1'b0;
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_err !== 1'b0) begin
            errors++;
            $display("FAIL clear_state: got rdy=%0b vld=%0b err=%0b expected 1 0 0", a_in_ready, a_out_valid, a_err);
        end
        a_row(8'sd21, 8'sd22);
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_wr_ptr_zero: got vld=%0b after first new row expected 0", a_out_valid);
        end
        a_row(8'sd23, 8'sd24);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_row !== 1'b0 || a_out_data[0] !== 8'sd21 || a_out_data[1] !== 8'sd22) begin
            errors++;
            $display("FAIL clear_new_tile: got vld=%0b row=%0d data=%0d,%0d expected 1 0 21,22",
                     a_out_valid, a_out_row, a_out_data[0], a_out_data[1]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_data[0] !== 8'sd0) begin
            errors++;
            $display("FAIL async_reset: got vld=%0b rdy=%0b data0=%0d expected 0 1 0", a_out_valid, a_in_ready, a_out_data[0]);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (a_out_valid !== 1'b0 || a_out_last !== 1'b0 || a_out_row !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got vld=%0b last=%0b row=%0d expected 0 0 0", a_out_valid, a_out_last, a_out_row);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        clear        = 1'b0;
        a_in_valid   = 1'b0;
        a_out_ready  = 1'b0;
        a_in_data[0] = '0;
        a_in_data[1] = '0;
        q_in_valid   = 1'b0;
        q_out_ready  = 1'b0;
        for (int i = 0; i < 4; i++) q_in_data[i] = '0;
        r_in_valid   = 1'b0;
        r_out_ready  = 1'b0;
        r_in_data[0] = '0;
        r_in_data[1] = '0;

        test_reset();
        test_basic_tile();
        test_requant();
        test_relu();
        test_backpressure();
        test_overflow();
        test_clear_and_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/da_row_collector.md
# da_row_collector

Downstream stage of the distributed-arithmetic GEMM column engine. The engine produces one row of `N` signed column results per completed bit-serial pass. This block:
- captures each row on a single-cycle strobe;
- requantizes every lane (optional ReLU, rounding right shift, saturation);
- buffers a full `M`-row tile;
- drains the tile one row per valid/ready beat to the next layer.

It stalls the engine through `in_ready` while draining.

## Interface
- `N`, default 1: output columns per row (lanes).
- `M`, default 1: rows per tile.
- `IN_WIDTH`, default 8: width of each signed lane from the engine.
- `OUT_WIDTH`, default 8: width of each signed requantized lane.
- `SHIFT`, default 0: arithmetic right shift applied during requantization, range 0..IN_WIDTH-1.
- `RELU_EN`, default 0: 1 clamps negative lanes to 0 before the shift.

Ports:
- `clk`  in  1  clock. One clock; reset is asynchronous and active-low.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous tile abort.
- `in_valid`  in  1  row strobe; one cycle per completed row.
- `in_data`  in  `IN_WIDTH` x `[N]`  signed row results.
- `in_ready`  out  1  block can accept a row this cycle.
- `out_valid`  out  1  drain beat valid.
- `out_ready`  in  1  consumer accepts the beat.
- `out_data`  out  `OUT_WIDTH` x `[N]`  requantized row.
- `out_row`  out  `$clog2(M)` (min 1)  row index of the current beat.
- `out_last`  out  1  beat carries row `M-1`.
- `err_overflow`  out  1  sticky flag: a row arrived while `in_ready`=0.

## Operation
- The FSM has two states:
  - FILL: `in_ready`=1, `out_valid`=0.
  - DRAIN: `in_ready`=0, `out_valid`=1.
- FILL:
  - Each `in_valid` writes the requantized row into `buf[wr_ptr]`, then increments `wr_ptr`.
  - The write at `wr_ptr`=M-1 wraps `wr_ptr` to 0 and moves the FSM to DRAIN.
- DRAIN:
  - `out_data`=`buf[rd_ptr]`, `out_row`=`rd_ptr`, `out_last`=(`rd_ptr`==M-1).
  - A beat transfers on `out_valid`&&`out_ready`, which increments `rd_ptr`.
  - The transfer at `rd_ptr`=M-1 wraps `rd_ptr` to 0 and returns the FSM to FILL.
- Requantization is applied per lane at write time, in this order:
  1. If `RELU_EN` and x<0, then x=0.
  2. If `SHIFT`>0, then x=(x + 2^(SHIFT-1)) >>> SHIFT (round half up). Compute this in `IN_WIDTH`+1 bits so the addition never wraps.
  3. Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Overflow: `in_valid` while in DRAIN drops the row, sets `err_overflow`, and leaves buffer and pointers unchanged. The flag clears only on reset.
- `clear` has top priority:
  - Next cycle the FSM is in FILL with `wr_ptr`=`rd_ptr`=0.
  - A coincident `in_valid` is dropped without an error.
  - Buffer contents are don't-care.
  - `err_overflow` is kept.
- `M`=1: every row strobe immediately produces one drain beat with `out_last`=1.

## Timing
- Reset (`rst_n` low): FSM=FILL, pointers=0, `in_ready`=1, `out_valid`=0, `out_row`=0, `out_last`=0, `err_overflow`=0, `out_data`=0. The buffer is cleared to 0.
- Latency: `in_valid` for row M-1 in cycle c gives `out_valid`=1 with row 0 in cycle c+1. `in_ready` falls in c+1.
- Drain throughput: 1 row/cycle while `out_ready`=1.
- After the last beat is accepted in cycle d, `in_ready`=1 in d+1. An `in_valid` in cycle d is an overflow.
- `out_data`, `out_row` and `out_last` hold stable while `out_valid`&&!`out_ready`.
- Reset asserted mid-tile returns all state to reset values asynchronously. No partial beat is emitted after release.

## Structure
- Shared package `da_pkg` holds:
  - the state enum `collector_state_t` {FILL, DRAIN};
  - the function `sat_signed(value, width)`.
- Sub-module `da_requant`: one combinational lane (ReLU, round-shift, saturate), instantiated N times in a generate loop.
- The buffer is a flat register array `[M][N]` of `OUT_WIDTH` bits; no RAM macro.

## Test plan
- Basic tile (N=2, M=2, IN=8, OUT=8, SHIFT=0): rows {5,-3} then {127,-128} -> beats row0 {5,-3}, row1 {127,-128} with `out_last`=1; `in_ready` returns to 1 the cycle after the last beat.
- Requantization (OUT=4, SHIFT=2, RELU_EN=0): in {100,-9,6,-128} -> {7,-2,2,-8}.
- Requantization, ReLU on (same settings, RELU_EN=1): in {-9, 6} -> {0, 2}.
- Backpressure: hold `out_ready`=0 for 5 cycles during DRAIN -> row 0 stays stable; release -> rows 0,1 on consecutive cycles.
- Overflow: pulse `in_valid` with {1,1} during DRAIN -> `err_overflow`=1 and drained data unchanged. A following tile completes normally with the flag still 1.
- Clear and reset: `clear` together with `in_valid` after one row of the tile is written -> next cycle FILL with `wr_ptr`=0, no error. A full new tile drains only the new rows. `rst_n` low mid-DRAIN -> `out_valid`=0 immediately.
